vc_read_scheduler: RTL and testbench

VC_READ_SCHEDULER -- requirements
Module: vc_read_scheduler

---
 rtl/vc_read_scheduler_if.sv | 28 ++
 rtl/vc_read_scheduler.sv | 122 ++++++++++++
 tb/tb_vc_read_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_read_scheduler_if.sv
// Flit-buffer / downstream-link bundle between the VC read scheduler and its environment.
// The master side is the scheduler; the slave side is the buffer, link and credit return.
interface vc_read_scheduler_if #(
    parameter int V    = 2,
    parameter int Fpay = 32
);
    localparam int Fw = 2 + V + Fpay;

    logic [V-1:0]  vc_not_empty;
    logic [Fw-1:0] dout_buf;
    logic          rd_en;
    logic [V-1:0]  vc_num_rd;
    logic [Fw-1:0] flit_out;
    logic          flit_out_wr;
    logic [V-1:0]  credit_in;
    logic [V-1:0]  credit_out;
    logic          proto_err;

    modport master (
        input  vc_not_empty, dout_buf, credit_in,
        output rd_en, vc_num_rd, flit_out, flit_out_wr, credit_out, proto_err
    );

    modport slave (
        output vc_not_empty, dout_buf, credit_in,
        input  rd_en, vc_num_rd, flit_out, flit_out_wr, credit_out, proto_err
    );
endinterface

// File: rtl/vc_read_scheduler.sv
// Credit-based round-robin reader of a multi-VC flit buffer with per-VC packet
// framing checks; rd_en at t, credit_out at t+1, flit_out_wr at t+2.
module vc_read_scheduler #(
    parameter int V    = 2,
    parameter int B    = 4,
    parameter int Fpay = 32
) (
    input  logic                clk,
    input  logic                reset,
    vc_read_scheduler_if.master bus
);
    localparam int Fw = 2 + V + Fpay;
    localparam int CW = $clog2(B + 1);
    localparam int PW = (V > 1) ? $clog2(V) : 1;

    typedef enum logic {HEAD_WAIT = 1'b0, BODY = 1'b1} pkt_state_e;

    logic [CW-1:0] credit_q [V];
    logic [CW-1:0] credit_d [V];
    pkt_state_e    state_q  [V];
    pkt_state_e    state_d  [V];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [V-1:0]  elig, gnt;
    logic [V-1:0]  vc_p1_q;
    logic          vld_p2_q;
    logic [Fw-1:0] flit_p2_q;
    logic          proto_err_q, proto_err_d;

    logic          flit_head, flit_tail;
    logic [V-1:0]  flit_vc;

    function automatic logic [CW-1:0] sat_credit(input logic [CW-1:0] c,
                                                 input logic          inc,
                                                 input logic          dec);
        logic [CW-1:0] r;
        r = c;
        if (inc && !dec && (c < CW'(B))) r = c + 1'b1;
        else if (dec && !inc && (c != '0)) r = c - 1'b1;
        return r;
    endfunction

    // Stage p0: eligibility and round-robin grant; a VC read last cycle is skipped
    // because its not-empty flag has not yet caught up with that read.
    always_comb begin
        int idx;
        elig  = '0;
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int k = 0; k < V; k++) begin
            elig[k] = bus.vc_not_empty[k] && (credit_q[k] != '0) && !vc_p1_q[k];
        end
        for (int k = 0; k < V; k++) begin
            idx = (int'(ptr_q) + k) % V;
            if ((gnt == '0) && elig[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = PW'((idx + 1) % V);
            end
        end
        if (reset) begin
            gnt   = '0;
            ptr_d = ptr_q;
        end
    end

    assign bus.rd_en      = |gnt;
    assign bus.vc_num_rd  = gnt;
    assign bus.credit_out = vc_p1_q & {V{~reset}};

    assign flit_head = bus.dout_buf[Fw-1];
    assign flit_tail = bus.dout_buf[Fw-2];
    assign flit_vc   = bus.dout_buf[Fw-3:Fpay];

    // Stage p1: credit bookkeeping and framing check of the flit returned by the buffer
    always_comb begin
        proto_err_d = proto_err_q;
        for (int i = 0; i < V; i++) begin
            credit_d[i] = sat_credit(credit_q[i], bus.credit_in[i], gnt[i]);
            state_d[i]  = state_q[i];
        end
        if (vc_p1_q != '0) begin
            if (flit_vc != vc_p1_q) proto_err_d = 1'b1;
            for (int i = 0; i < V; i++) begin
                if (vc_p1_q[i]) begin
                    if ((state_q[i] == HEAD_WAIT) && !flit_head) proto_err_d = 1'b1;
                    if ((state_q[i] == BODY) && flit_head)       proto_err_d = 1'b1;
                    if (flit_tail)      state_d[i] = HEAD_WAIT;
                    else if (flit_head) state_d[i] = BODY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                credit_q[i] <= CW'(B);
                state_q[i]  <= HEAD_WAIT;
            end
            ptr_q       <= '0;
            vc_p1_q     <= '0;
            vld_p2_q    <= 1'b0;
            flit_p2_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < V; i++) begin
                credit_q[i] <= credit_d[i];
                state_q[i]  <= state_d[i];
            end
            ptr_q       <= ptr_d;
            vc_p1_q     <= gnt;
            vld_p2_q    <= |vc_p1_q;
            proto_err_q <= proto_err_d;
            // Stage p2: output register holds its value between flits
            if (|vc_p1_q) flit_p2_q <= bus.dout_buf;
        end
    end

    assign bus.flit_out    = flit_p2_q;
    assign bus.flit_out_wr = vld_p2_q;
    assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_vc_read_scheduler.sv
// Directed bench for vc_read_scheduler: a behavioural flit buffer feeds the DUT and a
// scoreboard monitor compares every flit_out_wr against hand-computed expected flits.
module tb_vc_read_scheduler;
    localparam int V    = 2;
    localparam int B    = 4;
    localparam int Fpay = 8;
    localparam int FW   = 2 + V + Fpay;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    logic auto_cr  = 1'b0;

    logic [FW-1:0] q0 [$];
    logic [FW-1:0] q1 [$];
    logic [FW-1:0] exp_q [$];

    vc_read_scheduler_if #(.V(V), .Fpay(Fpay)) bus ();

    vc_read_scheduler #(.V(V), .B(B), .Fpay(Fpay)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [FW-1:0] mk(input logic h, input logic t,
                                         input logic [1:0] vc, input logic [7:0] p);
        return {h, t, vc, p};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every flit_out_wr must match the next expected flit
    always @(negedge clk) begin
        logic [FW-1:0] e;
        if (bus.flit_out_wr === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_flit: got %0h expected no flit", bus.flit_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.flit_out !== e) begin
                    n_err++;
                    $display("FAIL flit_out: got %0h expected %0h", bus.flit_out, e);
                end
            end
        end
    end

    task automatic push(input int vc, input logic [FW-1:0] f);
        if (vc == 0) q0.push_back(f);
        else         q1.push_back(f);
        bus.vc_not_empty = {q1.size() > 0, q0.size() > 0};
    endtask

    // One clock: sample outputs mid-cycle, then after the edge model the buffer read,
    // the not-empty flags and the credit return for the next cycle.
    task automatic tick(input logic [1:0] cr = 2'b00);
        logic       rd;
        logic [1:0] vsel;
        logic [1:0] cro;
        @(negedge clk);
        rd   = bus.rd_en;
        vsel = bus.vc_num_rd;
        cro  = bus.credit_out;
        @(posedge clk);
        #1;
        if (rd === 1'b1) begin
            if (vsel == 2'b01 && q0.size() > 0)      bus.dout_buf = q0.pop_front();
            else if (vsel == 2'b10 && q1.size() > 0) bus.dout_buf = q1.pop_front();
            else begin
                n_checks++;
                n_err++;
                $display("FAIL read_target: got vc_num_rd %b expected a non-empty VC", vsel);
            end
        end
        bus.vc_not_empty = {q1.size() > 0, q0.size() > 0};
        bus.credit_in    = (auto_cr ? cro : 2'b00) | cr;
        #1;
    endtask

    task automatic reset_on();
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        q0.delete();
        q1.delete();
        rst              = 1'b1;
        auto_cr          = 1'b0;
        bus.credit_in    = '0;
        bus.dout_buf     = '0;
        bus.vc_not_empty = '0;
        tick();
        tick();
        check("rst_flit_out_wr", 64'(bus.flit_out_wr), 64'd0);
        check("rst_credit_out", 64'(bus.credit_out), 64'd0);
        check("rst_proto_err", 64'(bus.proto_err), 64'd0);
        check("rst_flit_out", 64'(bus.flit_out), 64'd0);
        check("rst_credit0", 64'(dut.credit_q[0]), 64'd4);
        check("rst_credit1", 64'(dut.credit_q[1]), 64'd4);
    endtask

    task automatic reset_off(input logic [1:0] cr = 2'b00);
        rst           = 1'b0;
        bus.credit_in = cr;
        #1;
    endtask

    initial begin
        logic [FW-1:0] f1;
        rst              = 1'b1;
        bus.vc_not_empty = '0;
        bus.dout_buf     = '0;
        bus.credit_in    = '0;

        // Single-flit packet on VC0, latency and credit accounting
        reset_on();
        f1 = mk(1'b1, 1'b1, 2'b01, 8'hA1);
        push(0, f1);
        exp_q.push_back(f1);
        #1;
        check("rd_en_in_reset", 64'(bus.rd_en), 64'd0);
        reset_off();
        check("s1_rd_en_t", 64'(bus.rd_en), 64'd1);
        check("s1_vc_num_rd_t", 64'(bus.vc_num_rd), 64'h1);
        tick();
        check("s1_credit_out_t1", 64'(bus.credit_out), 64'h1);
        check("s1_rd_en_t1", 64'(bus.rd_en), 64'd0);
        check("s1_vc_num_rd_idle", 64'(bus.vc_num_rd), 64'd0);
        check("s1_credit0", 64'(dut.credit_q[0]), 64'd3);
        tick();
        check("s1_wr_t2", 64'(bus.flit_out_wr), 64'd1);
        check("s1_flit_t2", 64'(bus.flit_out), 64'(f1));
        check("s1_credit_out_t2", 64'(bus.credit_out), 64'd0);
        tick();
        check("s1_wr_t3", 64'(bus.flit_out_wr), 64'd0);
        check("s1_flit_hold", 64'(bus.flit_out), 64'(f1));

        // Two busy VCs with credit return: grants alternate, one flit per cycle
        reset_on();
        auto_cr = 1'b1;
        push(0, mk(1'b1, 1'b0, 2'b01, 8'h10));
        push(0, mk(1'b0, 1'b0, 2'b01, 8'h11));
        push(0, mk(1'b0, 1'b0, 2'b01, 8'h12));
        push(0, mk(1'b0, 1'b1, 2'b01, 8'h13));
        for (int i = 0; i < 4; i++) push(1, mk(1'b1, 1'b1, 2'b10, 8'(8'h20 + i)));
        exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 8'h10));
        exp_q.push_back(mk(1'b1, 1'b1, 2'b10, 8'h20));
        exp_q.push_back(mk(1'b0, 1'b0, 2'b01, 8'h11));
        exp_q.push_back(mk(1'b1, 1'b1, 2'b10, 8'h21));
        exp_q.push_back(mk(1'b0, 1'b0, 2'b01, 8'h12));
        exp_q.push_back(mk(1'b1, 1'b1, 2'b10, 8'h22));
        exp_q.push_back(mk(1'b0, 1'b1, 2'b01, 8'h13));
        exp_q.push_back(mk(1'b1, 1'b1, 2'b10, 8'h23));
        reset_off();
        for (int k = 0; k < 8; k++) begin
            check("s2_rd_en", 64'(bus.rd_en), 64'd1);
            check("s2_vc_num_rd", 64'(bus.vc_num_rd), (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k >= 2) check("s2_wr_stream", 64'(bus.flit_out_wr), 64'd1);
            tick();
        end
        check("s2_rd_en_done", 64'(bus.rd_en), 64'd0);
        check("s2_wr_t8", 64'(bus.flit_out_wr), 64'd1);
        tick();
        check("s2_wr_t9", 64'(bus.flit_out_wr), 64'd1);
        tick();
        check("s2_wr_t10", 64'(bus.flit_out_wr), 64'd0);
        check("s2_credit0_back", 64'(dut.credit_q[0]), 64'd4);
        check("s2_credit1_back", 64'(dut.credit_q[1]), 64'd4);
        check("s2_proto_ok", 64'(bus.proto_err), 64'd0);

        // Credit exhaustion on VC0 and release by one credit pulse
        reset_on();
        for (int i = 0; i < 6; i++) push(0, mk(1'b1, 1'b1, 2'b01, 8'(8'h30 + i)));
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b1, 1'b1, 2'b01, 8'(8'h30 + i)));
        reset_off();
        for (int c = 0; c < 10; c++) begin
            check("s3_rd_en", 64'(bus.rd_en), (c % 2 == 0 && c <= 6) ? 64'd1 : 64'd0);
            if (c == 8) check("s3_credit0_zero", 64'(dut.credit_q[0]), 64'd0);
            tick((c == 9) ? 2'b01 : 2'b00);
        end
        check("s3_rd_blocked_c10", 64'(bus.rd_en), 64'd0);
        tick();
        check("s3_rd_after_credit", 64'(bus.rd_en), 64'd1);
        check("s3_vc_after_credit", 64'(bus.vc_num_rd), 64'h1);
        tick();
        check("s3_rd_blocked_c12", 64'(bus.rd_en), 64'd0);
        tick();
        tick();

        // Credit arriving with a grant, and credit arriving at the ceiling
        reset_on();
        f1 = mk(1'b1, 1'b1, 2'b01, 8'h40);
        push(0, f1);
        exp_q.push_back(f1);
        reset_off(2'b01);
        check("s4_rd_en_t", 64'(bus.rd_en), 64'd1);
        tick();
        check("s4_credit0_same", 64'(dut.credit_q[0]), 64'd4);
        check("s4_credit_out", 64'(bus.credit_out), 64'h1);
        tick(2'b01);
        tick(2'b10);
        check("s4_credit0_sat", 64'(dut.credit_q[0]), 64'd4);
        tick();
        check("s4_credit1_sat", 64'(dut.credit_q[1]), 64'd4);
        tick();

        // Body flit without a head on VC1
        reset_on();
        f1 = mk(1'b0, 1'b0, 2'b10, 8'h50);
        push(1, f1);
        exp_q.push_back(f1);
        reset_off();
        check("s5a_vc_num_rd", 64'(bus.vc_num_rd), 64'h2);
        tick();
        check("s5a_proto_t1", 64'(bus.proto_err), 64'd0);
        tick();
        check("s5a_proto_t2", 64'(bus.proto_err), 64'd1);
        check("s5a_forwarded", 64'(bus.flit_out_wr), 64'd1);
        tick();
        tick();
        check("s5a_proto_held", 64'(bus.proto_err), 64'd1);

        // Head flit whose VC field names VC0 but is read from VC1
        reset_on();
        f1 = mk(1'b1, 1'b0, 2'b01, 8'h60);
        push(1, f1);
        exp_q.push_back(f1);
        reset_off();
        check("s5b_vc_num_rd", 64'(bus.vc_num_rd), 64'h2);
        tick();
        check("s5b_proto_t1", 64'(bus.proto_err), 64'd0);
        tick();
        check("s5b_proto_t2", 64'(bus.proto_err), 64'd1);
        tick();
        tick();

        // Reset the cycle after a grant: the in-flight read is dropped
        reset_on();
        push(0, mk(1'b1, 1'b1, 2'b01, 8'h70));
        reset_off();
        check("s6_rd_en_t", 64'(bus.rd_en), 64'd1);
        tick();
        rst = 1'b1;
        #1;
        check("s6_credit_out_in_rst", 64'(bus.credit_out), 64'd0);
        check("s6_rd_en_in_rst", 64'(bus.rd_en), 64'd0);
        tick();
        check("s6_wr_t2", 64'(bus.flit_out_wr), 64'd0);
        check("s6_credit_out_t2", 64'(bus.credit_out), 64'd0);
        check("s6_credit0", 64'(dut.credit_q[0]), 64'd4);
        check("s6_credit1", 64'(dut.credit_q[1]), 64'd4);
        rst = 1'b0;
        tick();
        check("s6_wr_t3", 64'(bus.flit_out_wr), 64'd0);
        check("s6_credit_out_t3", 64'(bus.credit_out), 64'd0);
        tick();
        tick();
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
